// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter that drives a single 3-to-8 decoder.
// State encodings and the {g1,g2a_bar,g2b_bar} enable patterns.
package decoder_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] OWN   = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SETUP = SETUP,
    ST_OWN   = OWN,
    ST_GAP   = GAP
  } state_t;

  // Ordered as {g1, g2a_bar, g2b_bar}
  localparam logic [2:0] DEC_EN  = 3'b100;
  localparam logic [2:0] DEC_DIS = 3'b011;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Requester/decoder-side signal bundle of the arbiter.
// The arbiter uses the slave modport; the requesting side uses master.
interface decoder_rr_arbiter_if;
  import decoder_arb_pkg::*;

  logic [7:0] req;
  logic       sel_a;
  logic       sel_b;
  logic       sel_c;
  logic       g1;
  logic       g2a_bar;
  logic       g2b_bar;
  logic       gnt_valid;
  logic [2:0] gnt_id;
  logic       timeout;

  modport master (
    output req,
    input  sel_a, sel_b, sel_c, g1, g2a_bar, g2b_bar, gnt_valid, gnt_id, timeout
  );

  modport slave (
    input  req,
    output sel_a, sel_b, sel_c, g1, g2a_bar, g2b_bar, gnt_valid, gnt_id, timeout
  );

endinterface

// File: rtl/decoder_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set req bit after last_id, wrapping.
// Offsets are scanned from farthest to nearest so the nearest set bit is the final write.
module rr_pick8
  import decoder_arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] last_id,
  output logic       any,
  output logic [2:0] win_id
);

  logic [2:0] cand;

  always_comb begin
    any    = |req;
    win_id = last_id;
    cand   = last_id;
    for (int i = 8; i >= 1; i--) begin
      cand = last_id + 3'(i);
      if (req[cand]) begin
        win_id = cand;
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner of one 74HC138: select setup, bounded enable window, dead time.
// All outputs come straight from registers.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int HOLD_MAX   = 15,
  parameter int GAP_CYCLES = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  decoder_rr_arbiter_if.slave bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] en_q, en_d;
  logic [2:0] last_q, last_d;
  logic       valid_q, valid_d;
  logic       tmo_q, tmo_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gap_q, gap_d;

  logic       pick_any;
  logic [2:0] pick_id;
  logic       owner_req;

  rr_pick8 u_pick (
    .req     (bus.req),
    .last_id (last_q),
    .any     (pick_any),
    .win_id  (pick_id)
  );

  assign owner_req = bus.req[sel_q];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    last_d  = last_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    hold_d  = hold_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          sel_d   = pick_id;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!owner_req) begin
          gap_d   = 4'd0;
          state_d = ST_GAP;
        end else begin
          en_d    = DEC_EN;
          valid_d = 1'b1;
          hold_d  = 8'd0;
          state_d = ST_OWN;
        end
      end
      ST_OWN: begin
        hold_d = hold_q + 8'd1;
        if (!owner_req || (hold_q == HOLD_LAST)) begin
          en_d    = DEC_DIS;
          valid_d = 1'b0;
          last_d  = sel_q;
          gap_d   = 4'd0;
          state_d = ST_GAP;
          // a release on the final cycle takes precedence over the timeout
          tmo_d   = owner_req;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        en_d    = DEC_DIS;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'd0;
      en_q    <= DEC_DIS;
      last_q  <= 3'd7;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      hold_q  <= 8'd0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.sel_a     = sel_q[0];
  assign bus.sel_b     = sel_q[1];
  assign bus.sel_c     = sel_q[2];
  assign bus.gnt_id    = sel_q;
  assign bus.g1        = en_q[2];
  assign bus.g2a_bar   = en_q[1];
  assign bus.g2b_bar   = en_q[0];
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = tmo_q;

endmodule

// File: doc/decoder_rr_arbiter.md
Name: decoder_rr_arbiter

Overview:
- Round-robin arbiter that shares one SN74HC138 3-to-8 decoder among 8 requesters.
- Picks a winner and drives the decoder select lines (A/B/C) and enables (G1, G2A_bar, G2B_bar), so exactly one decoder output line is the active grant strobe.
- Sequences select setup before enable, bounds grant length, and inserts dead time between owners.
- Sits between requesting lab peripherals and the decoder instance.

Parameters:
- HOLD_MAX, 15: maximum cycles a requester may hold the decoder enabled; range 1..255.
- GAP_CYCLES, 1: dead-time cycles with decoder disabled after each grant; range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  synchronous active-low reset.
- req  input  8  request per requester; level-held while ownership is wanted.
- sel_a  output  1  decoder A, the select LSB.
- sel_b  output  1  decoder B.
- sel_c  output  1  decoder C, the select MSB.
- g1  output  1  decoder G1 enable; active high.
- g2a_bar  output  1  decoder G2A_bar enable; active low.
- g2b_bar  output  1  decoder G2B_bar enable; active low.
- gnt_valid  output  1  high while the decoder is enabled for gnt_id.
- gnt_id  output  3  current or most recent owner index, equal to {sel_c,sel_b,sel_a}.
- timeout  output  1  one-cycle pulse when a grant is ended by HOLD_MAX.

Behaviour:
- Clock and reset: single clock clk. reset_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values:
  - State=IDLE.
  - sel_a/b/c=0 and gnt_id=0.
  - g1=0, g2a_bar=1, g2b_bar=1 (decoder disabled, all outputs inactive).
  - gnt_valid=0, timeout=0, hold_cnt=0, gap_cnt=0.
  - last_id=7, so requester 0 has first priority after reset.
- Reset asserted in any state takes effect at the next edge: decoder is disabled that edge and no timeout pulse is produced.
- All outputs are registered. The decoder enables are never asserted in the same cycle that the select lines change.
- Winner selection: the first set bit of req, searching from (last_id+1) mod 8 upward with wrap-around. Only req bits are considered.
- States:
  - IDLE:
    - req==0: remain in IDLE.
    - Otherwise: load winner into sel/gnt_id and go to SETUP. Enables stay off.
  - SETUP (exactly 1 cycle):
    - req[gnt_id]==0: abort to GAP. Enables stay off, last_id is unchanged, gap_cnt=0.
    - Otherwise: assert g1=1, g2a_bar=0, g2b_bar=0, gnt_valid=1, set hold_cnt=0, go to OWN.
  - OWN:
    - Each cycle, hold_cnt increments (8-bit).
    - Release: req[gnt_id]==0 ends the grant.
    - Timeout: hold_cnt==HOLD_MAX-1 ends the grant and pulses timeout=1 for one cycle.
    - If release and timeout coincide, release wins and there is no timeout pulse.
    - On exit: deassert enables and gnt_valid, set last_id=gnt_id, gap_cnt=0, go to GAP.
    - Select lines hold their value.
  - GAP:
    - Decoder stays disabled and selects are held.
    - gap_cnt increments; when gap_cnt==GAP_CYCLES-1, go to IDLE.
- Latency: req sampled high in IDLE at edge N gives selects valid after N and enables valid after N+1. Enables are high for at most HOLD_MAX cycles.
- A timed-out requester still asserting req re-competes in round-robin order. If it is the sole requester, it is re-granted after GAP.
- Changes to req for non-owners during SETUP/OWN/GAP have no effect until the next IDLE.
- Invariant: gnt_valid == (g1 && !g2a_bar && !g2b_bar).

Decomposition:
- Shared package decoder_arb_pkg:
  - State encoding localparams: IDLE=2'd0, SETUP=2'd1, OWN=2'd2, GAP=2'd3.
  - Decoder enable constants: DEC_EN={1,0,0} and DEC_DIS={0,1,1} for {g1,g2a_bar,g2b_bar}.
- One natural sub-module: rr_pick8, a combinational round-robin picker.
  - Inputs: req[7:0], last_id[2:0].
  - Outputs: any, win_id[2:0].
- The FSM, hold/gap counters and output registers stay in the top module.

Test Plan:
- Reset then req=8'h01 held → sel=000 one edge after sampling, enables asserted the following edge. With GAP_CYCLES=1 and req held, timeout pulses after 15 enabled cycles, then 1 disabled cycle, then re-grant to 0.
- req=8'hFF held, HOLD_MAX=3 → grant order 0,1,2,…,7,0. Each grant has 3 enabled cycles with a timeout pulse, and a 1-cycle gap between grants.
- last_id=5 and req=8'h21 → grant 0 (wrap-around), then 5 on the next arbitration.
- Owner 3 drops req in the same cycle hold_cnt reaches HOLD_MAX-1 → no timeout pulse and last_id=3.
- req[4] pulsed for one cycle so it is low in SETUP → enables are never asserted, the FSM goes to GAP then IDLE, and last_id is unchanged.
- reset_n=0 asserted mid-OWN → at the next edge g1=0, g2a_bar=g2b_bar=1, gnt_valid=0, sel=000, and the next grant starts from requester 0.
